// File: rtl/div_seq_pkg.sv
// Shared types and width helpers for the sequential divider.
package div_seq_pkg;

  localparam int unsigned DIV_DEF_WIDTH = 32;

  // Controller states.
  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_BUSY   = 2'd2,
    DIV_FINISH = 2'd3
  } div_state_e;

  // Iteration counter width: enough to count WIDTH steps, never zero.
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Packed {remainder, quotient} result width.
  function automatic int unsigned div_res_w(input int unsigned width);
    return 2 * width;
  endfunction

  localparam int unsigned DIV_DEF_CNT_W = div_cnt_w(DIV_DEF_WIDTH);
  localparam int unsigned DIV_DEF_RES_W = div_res_w(DIV_DEF_WIDTH);

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The stored remainder is always below the divisor, so WIDTH bits hold it;
  // the shifted value and trial difference need the extra sign bit.
  always_comb begin
    shifted = {part_rem, next_bit};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    new_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU unit: restoring divider with sign fix-up, {remainder, quotient} result.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   annul,
  input  logic                   signed_div,
  input  logic [WIDTH-1:0]       opdata1,
  input  logic [WIDTH-1:0]       opdata2,
  output logic [2*WIDTH-1:0]     result,
  output logic                   ready,
  output logic                   busy
);

  localparam int unsigned CNT_W = div_cnt_w(WIDTH);
  localparam int unsigned RES_W = div_res_w(WIDTH);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] next_quo;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;
  logic [RES_W-1:0] byzero_res;

  // Operand magnitudes for signed mode; unsigned operands pass through.
  always_comb begin
    mag1 = (signed_div && opdata1[WIDTH-1]) ? (-opdata1) : opdata1;
    mag2 = (signed_div && opdata2[WIDTH-1]) ? (-opdata2) : opdata2;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .part_rem (rem),
    .next_bit (dvd[WIDTH-1]),
    .divisor  (dvs),
    .new_rem  (step_rem),
    .q_bit    (step_q)
  );

  // Final-step quotient and sign-corrected results, consumed on the last BUSY edge.
  always_comb begin
    next_quo   = {quo[WIDTH-2:0], step_q};
    fix_q      = neg_q ? (-next_quo) : next_quo;
    fix_r      = neg_r ? (-step_rem) : step_rem;
    byzero_res = {dvd, {WIDTH{1'b1}}};
  end

  // Controller and datapath registers; rst overrides annul and start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      quo    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (start && !annul) begin
            neg_q <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_r <= signed_div & opdata1[WIDTH-1];
            dvs   <= mag2;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            if (opdata2 == '0) begin
              // Divide-by-zero reports the raw dividend as remainder.
              dvd   <= opdata1;
              state <= DIV_BYZERO;
            end else begin
              dvd   <= mag1;
              state <= DIV_BUSY;
            end
          end
        end
        DIV_BYZERO: begin
          busy <= 1'b0;
          if (annul) begin
            state <= DIV_IDLE;
          end else begin
            result <= byzero_res;
            ready  <= 1'b1;
            state  <= DIV_FINISH;
          end
        end
        DIV_BUSY: begin
          if (annul) begin
            busy  <= 1'b0;
            state <= DIV_IDLE;
          end else begin
            rem <= step_rem;
            quo <= next_quo;
            dvd <= {dvd[WIDTH-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              result <= {fix_r, fix_q};
              ready  <= 1'b1;
              busy   <= 1'b0;
              state  <= DIV_FINISH;
            end
          end
        end
        DIV_FINISH: begin
          state <= DIV_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (WIDTH=32).
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .annul      (annul),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge (start of the next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one division in the current cycle and wait (bounded) for ready.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!ready && lat < 60) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    tick();
    chk({tag, " ready_drop"}, 64'(ready), 64'd0);
  endtask

  initial begin
    int pulses;
    int pulse_cyc;
    logic prev_ready;

    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset result", result, 64'd0);

    // Unsigned 100/7 with per-cycle busy/ready timing.
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      chk($sformatf("u100/7 busy c%0d", c), 64'(busy), 64'd1);
      chk($sformatf("u100/7 ready c%0d", c), 64'(ready), 64'd0);
      tick();
    end
    chk("u100/7 ready c33", 64'(ready), 64'd1);
    chk("u100/7 busy c33", 64'(busy), 64'd0);
    chk("u100/7 result", result, {32'h0000_0002, 32'h0000_000E});
    tick();
    chk("u100/7 ready c34", 64'(ready), 64'd0);

    // start together with annul in IDLE is ignored.
    opdata1 = 32'd9; opdata2 = 32'd3; start = 1'b1; annul = 1'b1;
    tick();
    start = 1'b0; annul = 1'b0;
    chk("start+annul busy", 64'(busy), 64'd0);
    tick();
    chk("start+annul ready", 64'(ready), 64'd0);
    chk("start+annul result", result, {32'h0000_0002, 32'h0000_000E});

    run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("s7/-2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 33, {32'h0000_0001, 32'hFFFF_FFFD});
    run_div("u5/0", 1'b0, 32'h0000_0005, 32'h0000_0000, 2, {32'h0000_0005, 32'hFFFF_FFFF});
    run_div("s5/0", 1'b1, 32'h0000_0005, 32'h0000_0000, 2, {32'h0000_0005, 32'hFFFF_FFFF});
    run_div("s-5/0", 1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 2, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0000_0000, 32'h8000_0000});
    run_div("uFF/1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 33, {32'h0000_0000, 32'hFFFF_FFFF});
    run_div("uFF/16", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 33, {32'h0000_000F, 32'h0FFF_FFFF});

    // annul while in BYZERO: no ready, result held.
    signed_div = 1'b0; opdata1 = 32'd77; opdata2 = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("byz_annul busy c1", 64'(busy), 64'd1);
    annul = 1'b1;
    tick();
    annul = 1'b0;
    chk("byz_annul ready c2", 64'(ready), 64'd0);
    chk("byz_annul busy c2", 64'(busy), 64'd0);
    tick();
    chk("byz_annul ready c3", 64'(ready), 64'd0);
    chk("byz_annul result", result, {32'h0000_000F, 32'h0FFF_FFFF});

    // annul at cycle 10 of a BUSY division, then an immediate new start.
    opdata1 = 32'd5000; opdata2 = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    chk("annul busy c11", 64'(busy), 64'd0);
    chk("annul ready c11", 64'(ready), 64'd0);
    chk("annul result c11", result, {32'h0000_000F, 32'h0FFF_FFFF});
    run_div("post_annul u1000/3", 1'b0, 32'd1000, 32'd3, 33, {32'h0000_0001, 32'h0000_014D});

    // start held high through BUSY and FINISH: exactly one ready pulse.
    signed_div = 1'b0; opdata1 = 32'd200; opdata2 = 32'd7; start = 1'b1;
    pulses = 0; pulse_cyc = -1; prev_ready = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      tick();
      if (c == 34) begin
        start = 1'b0;
        chk("held_start busy c34", 64'(busy), 64'd0);
      end
      if (ready) begin
        pulses++;
        pulse_cyc = c;
        chk("held_start result", result, {32'h0000_0004, 32'h0000_001C});
      end
      if (prev_ready && ready) chk("held_start back2back", 64'd1, 64'(ready && !prev_ready));
      prev_ready = ready;
    end
    chk("held_start pulses", 64'(pulses), 64'd1);
    chk("held_start pulse cycle", 64'(pulse_cyc), 64'd33);

    // rst at cycle 20 of a division.
    opdata1 = 32'h1234_5678; opdata2 = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst ready", 64'(ready), 64'd0);
    chk("rst result", result, 64'd0);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ready) pulses++;
    end
    chk("rst no_ready", 64'(pulses), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle integer divider for the execute stage. Serves MIPS DIV/DIVU.
- Produces quotient and remainder for the HI/LO write-back using a radix-2 restoring algorithm.
- Each iteration does one (WIDTH+1)-bit trial subtraction.
- Sits beside the adder/multiplier datapath. The pipeline controller stalls while busy is high.

Parameters:
- WIDTH, 32, operand width in bits. Result width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a division. Sampled only in IDLE.
- annul  in  1  cancel the in-flight division (branch flush or exception)
- signed_div  in  1  1 = two's-complement DIV, 0 = DIVU. Latched with start.
- opdata1  in  WIDTH  dividend. Latched with start.
- opdata2  in  WIDTH  divisor. Latched with start.
- result  out  2*WIDTH  {remainder, quotient}. Valid only while ready=1.
- ready  out  1  single-cycle completion strobe
- busy  out  1  high from the cycle after start is accepted until ready is asserted

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, result=0, ready=0, busy=0, iteration counter=0.
  - rst has priority over annul and start, including mid-operation.
- States: IDLE, BYZERO, BUSY, FINISH.
- IDLE:
  - start=1 and annul=0 latches operands and signed_div.
  - Divisor==0 → BYZERO. Otherwise → BUSY, with counter=0.
  - start=1 together with annul=1 is ignored.
- Operand prep on accept:
  - Signed mode: each negative operand is replaced by its two's-complement magnitude.
  - Record neg_q = sign(op1) XOR sign(op2) and neg_r = sign(op1).
  - Unsigned mode: neg_q=neg_r=0.
- BUSY, one step per cycle:
  - Partial remainder R (WIDTH+1 bits) is shifted left with the next dividend MSB.
  - trial = R − {0,divisor}.
  - trial non-negative: R=trial and quotient bit=1. Otherwise R is kept and quotient bit=0.
  - The counter increments each cycle. After the WIDTH-th step (counter==WIDTH−1) → FINISH.
- FINISH, one cycle:
  - ready=1, busy=0.
  - result = {neg_r ? −R : R, neg_q ? −Q : Q}, truncated to WIDTH each.
  - Next edge → IDLE unconditionally. start in the FINISH cycle is ignored.
- BYZERO: goes to FINISH on the next edge with Q=all ones and R=dividend (raw, unsigned view). This is architecturally UNPREDICTABLE but fixed here for determinism.
- Latency:
  - start accepted at edge k → ready high in the cycle after edge k+WIDTH, i.e. 33 cycles after the start cycle for WIDTH=32.
  - Divide-by-zero → ready in the 2nd cycle after start.
- annul in BUSY or BYZERO → IDLE at the next edge. No ready pulse; result is held at its previous value.
- annul in FINISH has no effect on that cycle's ready.
- start while busy is ignored. No queuing.
- Overflow case −2^(WIDTH−1) / −1 (signed): Q=0x80000000, R=0. This falls out of the magnitude arithmetic with no special casing.
- result holds its last FINISH value until the next FINISH or rst.
- ready is never high for two consecutive cycles.

Decomposition:
- Shared package:
  - State encoding constants: DIV_IDLE, DIV_BYZERO, DIV_BUSY, DIV_FINISH.
  - Width-derived constants for the counter width ($clog2(WIDTH)) and the result width.
- One sub-module, div_step:
  - Combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Keeps the trial subtract isolated for timing.
- The sign fix-up negations stay in div_seq.

Test Plan:
- Unsigned 100/7: start at cycle 0 → ready=1 only in cycle 33; result={0x00000002, 0x0000000E}; busy high for cycles 1–32.
- Signed −7/2 (0xFFFFFFF9, 0x00000002) → Q=0xFFFFFFFD, R=0xFFFFFFFF.
- Signed 7/−2 → Q=0xFFFFFFFD, R=0x00000001.
- Divide by zero 5/0 (either mode) → ready in cycle 2, result={0x00000005, 0xFFFFFFFF}.
- Signed 0x80000000 / 0xFFFFFFFF → Q=0x80000000, R=0. Unsigned 0xFFFFFFFF/1 → Q=0xFFFFFFFF, R=0.
- Interrupts:
  - annul at cycle 10 of a division → busy=0 from cycle 11, no ready, result unchanged; an immediate new start completes correctly.
  - rst at cycle 20 → next cycle busy=0, ready=0, result=0.
  - start held high during BUSY → exactly one ready pulse.
